// File: rtl/frame_buffer_writer.sv
// Raster RGB stream to four slice memories: tracks x/y, derives slice and
// linear address incrementally, resyncs on SOF and flags framing events.
module frame_buffer_writer #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int SLICE_LINES = 150,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [23:0]       pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [1:0]        wr_slice,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_red,
    output logic [7:0]        wr_green,
    output logic [7:0]        wr_blue,
    output logic              frame_done,
    output logic              sof_err,
    output logic [15:0]       drop_count,
    output logic              busy
);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [7:0] L_LAST = 8'(SLICE_LINES - 1);

    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_nx;

    logic [9:0]        x, x_nx, y, y_nx;
    logic [7:0]        line, line_nx;
    logic [1:0]        slice, slice_nx, wr_slice_nx;
    logic [ADDR_W-1:0] addr, addr_nx, wr_addr_nx;
    logic [23:0]       wr_data, wr_data_nx;
    logic [15:0]       drop_nx;
    logic              wr_en_nx, frame_done_nx, sof_err_nx;
    logic              accept, last_pix, restart;

    assign pix_ready = !reset;
    assign accept    = pix_valid && !reset;
    assign last_pix  = (x == X_LAST) && (y == Y_LAST);
    // SOF on the final pixel is treated as that pixel, so frame_done wins.
    assign restart   = pix_sof && !(x == 10'd0 && y == 10'd0) && !last_pix;
    assign busy      = (state == WRITE);
    assign {wr_red, wr_green, wr_blue} = wr_data;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            case (state)
                IDLE:    if (pix_sof) state_nx = WRITE;
                WRITE:   if (last_pix) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        x_nx = x; y_nx = y; line_nx = line; slice_nx = slice; addr_nx = addr;
        wr_slice_nx = wr_slice; wr_addr_nx = wr_addr; wr_data_nx = wr_data;
        drop_nx = drop_count;
        wr_en_nx = 1'b0; frame_done_nx = 1'b0; sof_err_nx = 1'b0;
        if (accept) begin
            if (state == IDLE && !pix_sof) begin
                if (drop_count != 16'hFFFF) drop_nx = drop_count + 16'd1;
            end else begin
                wr_en_nx   = 1'b1;
                wr_data_nx = pix_data;
                if (state == IDLE || restart) begin
                    // (0,0) write; counters restart one pixel in
                    sof_err_nx  = (state == WRITE);
                    wr_slice_nx = 2'd0;
                    wr_addr_nx  = '0;
                    x_nx = 10'd1; y_nx = 10'd0; line_nx = 8'd0;
                    slice_nx = 2'd0; addr_nx = ADDR_W'(1);
                end else begin
                    wr_slice_nx = slice;
                    wr_addr_nx  = addr;
                    if (last_pix) begin
                        frame_done_nx = 1'b1;
                        x_nx = 10'd0; y_nx = 10'd0; line_nx = 8'd0;
                        slice_nx = 2'd0; addr_nx = '0;
                    end else if (x == X_LAST) begin
                        x_nx = 10'd0;
                        y_nx = y + 10'd1;
                        if (line == L_LAST) begin
                            line_nx  = 8'd0;
                            slice_nx = slice + 2'd1;
                            addr_nx  = '0;
                        end else begin
                            line_nx = line + 8'd1;
                            addr_nx = addr + ADDR_W'(1);
                        end
                    end else begin
                        x_nx    = x + 10'd1;
                        addr_nx = addr + ADDR_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0; y <= '0; line <= '0; slice <= '0; addr <= '0;
            wr_en <= 1'b0; wr_slice <= '0; wr_addr <= '0; wr_data <= '0;
            frame_done <= 1'b0; sof_err <= 1'b0; drop_count <= '0;
        end else begin
            x <= x_nx; y <= y_nx; line <= line_nx; slice <= slice_nx; addr <= addr_nx;
            wr_en <= wr_en_nx; wr_slice <= wr_slice_nx; wr_addr <= wr_addr_nx;
            wr_data <= wr_data_nx; frame_done <= frame_done_nx;
            sof_err <= sof_err_nx; drop_count <= drop_nx;
        end
    end
endmodule
